// File: rtl/uart_pkg.sv
// uart_pkg: parameters shared by the UART path (tx_uart, rx_uart, rx_fifo).
//   BW         - UART frame parameter; the data byte is BW-1 bits wide.
//   DATA_W     - payload width carried through the FIFO.
//   DEPTH_LOG2 - default log2 of the receive FIFO entry count.
package uart_pkg;
   localparam int BW         = 9;
   localparam int DATA_W     = BW - 1;
   localparam int DEPTH_LOG2 = 4;
endpackage

// File: rtl/rx_fifo_mem.sv
// rx_fifo_mem: storage array for rx_fifo, 2**DEPTH_LOG2 x DATA_W.
// Synchronous write, asynchronous read, so it maps onto distributed RAM.
// The contents are deliberately not reset.
// Ports:
//   clk   - system clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data, combinational from the array
module rx_fifo_mem
   import uart_pkg::*;
#(
   parameter int DW  = DATA_W,
   parameter int AW  = DEPTH_LOG2
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [2**AW];

   // Write port.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/rx_fifo.sv
// rx_fifo: first-word fall-through receive buffer between rx_uart and a
// byte consumer. rx_uart cannot be stalled, so a write into a full FIFO
// with no pop in the same cycle is dropped and reported on o_overrun.
// Optional build macro: RX_FIFO_STICKY_OVERRUN_EN - when defined,
// o_overrun stays high from a dropped write until the next pop; otherwise
// it is a one-cycle pulse in the cycle after the drop.
// Ports:
//   clk        - system clock, rising edge
//   i_reset    - asynchronous active-high reset
//   i_wr_valid - one-cycle strobe, byte received
//   i_wr_data  - received byte
//   o_rd_valid - head entry available
//   o_rd_data  - head entry (meaningful while o_rd_valid)
//   i_rd_ready - consumer accepts the head entry
//   o_count    - occupancy 0..DEPTH
//   o_full     - occupancy == DEPTH
//   o_empty    - occupancy == 0
//   o_overrun  - a write was dropped
module rx_fifo
   import uart_pkg::*;
#(
   parameter int BW_P         = BW,
   parameter int DEPTH_LOG2_P = DEPTH_LOG2
) (
   input  logic                    clk,
   input  logic                    i_reset,
   input  logic                    i_wr_valid,
   input  logic [BW_P-2:0]         i_wr_data,
   output logic                    o_rd_valid,
   output logic [BW_P-2:0]         o_rd_data,
   input  logic                    i_rd_ready,
   output logic [DEPTH_LOG2_P:0]   o_count,
   output logic                    o_full,
   output logic                    o_empty,
   output logic                    o_overrun
);

   localparam int DW = BW_P - 1;
   localparam int AW = DEPTH_LOG2_P;
   localparam int PW = DEPTH_LOG2_P + 1;

   // Pointers carry one extra MSB so that full and empty are distinguishable.
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr_nxt;
   logic [PW-1:0] rd_ptr_nxt;
   logic [PW-1:0] count_nxt;
   logic          push;
   logic          pop;
   logic          drop;
   logic          full_nxt;
   logic          empty_nxt;
   logic          overrun_nxt;

   rx_fifo_mem #(
      .DW (DW),
      .AW (AW)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (i_wr_data),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (o_rd_data)
   );

   // Handshake decode, next pointers, next occupancy and next flags.
   always_comb begin
      pop         = o_rd_valid & i_rd_ready;
      // A pop in the same cycle frees a slot, so a full FIFO still accepts.
      push        = i_wr_valid & (~o_full | pop);
      drop        = i_wr_valid & o_full & ~pop;
      wr_ptr_nxt  = wr_ptr;
      rd_ptr_nxt  = rd_ptr;
      count_nxt   = o_count;
      if (push) begin
         wr_ptr_nxt = wr_ptr + PW'(1);
      end else begin
         wr_ptr_nxt = wr_ptr;
      end
      if (pop) begin
         rd_ptr_nxt = rd_ptr + PW'(1);
      end else begin
         rd_ptr_nxt = rd_ptr;
      end
      case ({push, pop})
         2'b10:   count_nxt = o_count + PW'(1);
         2'b01:   count_nxt = o_count - PW'(1);
         default: count_nxt = o_count;
      endcase
      empty_nxt = (wr_ptr_nxt == rd_ptr_nxt);
      full_nxt  = (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]) &&
                  (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]);
`ifdef RX_FIFO_STICKY_OVERRUN_EN
      // Drop and pop are mutually exclusive, so the order here is safe.
      if (drop) begin
         overrun_nxt = 1'b1;
      end else if (pop) begin
         overrun_nxt = 1'b0;
      end else begin
         overrun_nxt = o_overrun;
      end
`else
      overrun_nxt = drop;
`endif
   end

   // State and registered status outputs.
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         wr_ptr     <= {PW{1'b0}};
         rd_ptr     <= {PW{1'b0}};
         o_count    <= {PW{1'b0}};
         o_empty    <= 1'b1;
         o_full     <= 1'b0;
         o_rd_valid <= 1'b0;
         o_overrun  <= 1'b0;
      end else begin
         wr_ptr     <= wr_ptr_nxt;
         rd_ptr     <= rd_ptr_nxt;
         o_count    <= count_nxt;
         o_empty    <= empty_nxt;
         o_full     <= full_nxt;
         o_rd_valid <= ~empty_nxt;
         o_overrun  <= overrun_nxt;
      end
   end

endmodule

// File: tb/tb_rx_fifo.sv
// tb_rx_fifo: directed, scoreboard-based bench for rx_fifo.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_rx_fifo;

   logic       clk = 1'b0;
   logic       i_reset;
   logic       i_wr_valid;
   logic [7:0] i_wr_data;
   logic       o_rd_valid;
   logic [7:0] o_rd_data;
   logic       i_rd_ready;
   logic [4:0] o_count;
   logic       o_full;
   logic       o_empty;
   logic       o_overrun;

   int         compared = 0;
   int         mismatched = 0;
   logic [7:0] sb [$];
   int         mc = 0;
   logic       exp_ovr = 1'b0;

   rx_fifo dut (
      .clk        (clk),
      .i_reset    (i_reset),
      .i_wr_valid (i_wr_valid),
      .i_wr_data  (i_wr_data),
      .o_rd_valid (o_rd_valid),
      .o_rd_data  (o_rd_data),
      .i_rd_ready (i_rd_ready),
      .o_count    (o_count),
      .o_full     (o_full),
      .o_empty    (o_empty),
      .o_overrun  (o_overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_state();
      chk("count",    32'(o_count),    32'(mc));
      chk("empty",    32'(o_empty),    32'(mc == 0));
      chk("full",     32'(o_full),     32'(mc == 16));
      chk("rd_valid", 32'(o_rd_valid), 32'(mc != 0));
      chk("overrun",  32'(o_overrun),  32'(exp_ovr));
      if (mc != 0) chk("rd_data", 32'(o_rd_data), 32'(sb[0]));
   endtask

   // One clock of stimulus: check current state, drive, advance the model.
   task automatic step(input logic wv, input logic [7:0] wd, input logic rdy);
      logic pm, pu, dr;
      check_state();
      i_wr_valid = wv;
      i_wr_data  = wd;
      i_rd_ready = rdy;
      pm = (mc != 0) && rdy;
      pu = wv && ((mc < 16) || pm);
      dr = wv && (mc == 16) && !pm;
      @(posedge clk);
      if (pm) void'(sb.pop_front());
      if (pu) sb.push_back(wd);
      mc = mc + int'(pu) - int'(pm);
`ifdef RX_FIFO_STICKY_OVERRUN_EN
      if (dr) exp_ovr = 1'b1;
      else if (pm) exp_ovr = 1'b0;
`else
      exp_ovr = dr;
`endif
      @(negedge clk);
   endtask

   initial begin
      i_reset    = 1'b1;
      i_wr_valid = 1'b0;
      i_wr_data  = 8'h00;
      i_rd_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      i_reset = 1'b0;

      // Reset then idle.
      step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b0);

      // Two pushes, then one pop, then drain.
      step(1'b1, 8'h41, 1'b0);
      step(1'b1, 8'h42, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b0);

      // Ready while empty is ignored; write still lands.
      step(1'b1, 8'h77, 1'b1);
      step(1'b0, 8'h00, 1'b1);

      // Fill, overrun on 17th, then drain.
      for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
      step(1'b1, 8'hAA, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b0);

      // Full with simultaneous write and pop.
      for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
      step(1'b1, 8'h55, 1'b1);
      for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b0);

      // Stream with ready toggling; pointers wrap.
      for (int i = 0; i < 40; i++) step(1'b1, 8'(8'h60 + i), 1'(i % 2));
      while (mc != 0) step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b0);

      // Reset mid-stream, observed before any clock edge.
      step(1'b1, 8'hC1, 1'b0);
      step(1'b1, 8'hC2, 1'b0);
      step(1'b1, 8'hC3, 1'b0);
      check_state();
      i_wr_valid = 1'b0;
      #2;
      i_reset = 1'b1;
      #1;
      chk("rst_rd_valid", 32'(o_rd_valid), 32'd0);
      chk("rst_count",    32'(o_count),    32'd0);
      chk("rst_empty",    32'(o_empty),    32'd1);
      sb.delete();
      mc = 0;
      exp_ovr = 1'b0;
      @(posedge clk);
      @(negedge clk);
      i_reset = 1'b0;
      step(1'b1, 8'hD4, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      check_state();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/rx_fifo.md
Name: rx_fifo

Overview:
- Receive-side elastic buffer between rx_uart and a byte consumer (command parser or loopback into tx).
- rx_uart emits one-cycle valid strobes and cannot be stalled. This block absorbs them and presents bytes on a valid/ready read port.
- First-word fall-through (show-ahead) FIFO with occupancy count, full/empty flags and overrun reporting.

Parameters:
- BW, 9, UART frame parameter shared with tx/rx_uart; data width is BW-1 (8 bits).
- DEPTH_LOG2, 4, log2 of entry count; DEPTH = 2**DEPTH_LOG2 = 16.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_wr_valid  input  1  one-cycle strobe from rx_uart; byte received.
- i_wr_data  input  BW-1  received byte, valid with i_wr_valid.
- o_rd_valid  output  1  head entry available (FIFO not empty).
- o_rd_data  output  BW-1  head entry; meaningful only while o_rd_valid.
- i_rd_ready  input  1  consumer accepts head; pop when o_rd_valid && i_rd_ready.
- o_count  output  DEPTH_LOG2+1  current occupancy, 0..DEPTH.
- o_full  output  1  o_count == DEPTH.
- o_empty  output  1  o_count == 0.
- o_overrun  output  1  write was dropped (see Behaviour).

Behaviour:
- Reset (async assert, sync-safe deassert is the integrator's job):
  - rd/wr pointers = 0, o_count = 0, o_empty = 1, o_full = 0, o_rd_valid = 0, o_overrun = 0.
  - o_rd_data = don't-care.
  - Memory contents are not reset.
- Pointers are DEPTH_LOG2+1 bits; the MSB distinguishes full from empty.
  - empty: ptrs equal.
  - full: low bits equal, MSBs differ.
  - Pointers wrap naturally modulo 2*DEPTH.
- Write acceptance: push = i_wr_valid && (!o_full || pop). The byte is stored at mem[wr_ptr[DEPTH_LOG2-1:0]] and wr_ptr increments.
- Pop: pop = o_rd_valid && i_rd_ready; rd_ptr increments.
- o_rd_data = mem[rd_ptr low bits]. The read is combinational from the registered array (FWFT).
- Latency: a push in cycle N into an empty FIFO gives o_rd_valid = 1 with that byte in cycle N+1. There is no same-cycle bypass; i_rd_ready while empty is ignored.
- o_count: +1 on push only, -1 on pop only, unchanged on both or neither. o_full, o_empty and o_rd_valid are registered-consistent with o_count every cycle.
- Full with simultaneous write and pop: both occur, count stays DEPTH, no overrun.
- Full with write and no pop: byte dropped, contents and pointers unchanged, o_overrun pulses high for exactly the next cycle.
- Empty with simultaneous write and i_rd_ready: only the write takes effect.
- Reset mid-stream: all queued bytes are discarded immediately; o_rd_valid drops asynchronously.
- i_wr_data is not required to be stable outside i_wr_valid.

Optional Feature:
- Macro: RX_FIFO_STICKY_OVERRUN_EN.
- Defined:
  - o_overrun sets on a dropped write and stays high until the next pop, or until reset.
  - A drop in the same cycle as a pop cannot occur, because a pop frees a slot.
- Undefined: o_overrun is the one-cycle pulse described above.
- Port list is identical in both builds.

Decomposition:
- Shared package uart_pkg holds:
  - BW default.
  - DATA_W = BW-1.
  - Default DEPTH_LOG2.
- Natural sub-module: rx_fifo_mem.
  - 2**DEPTH_LOG2 x DATA_W array.
  - Synchronous write, asynchronous read.
  - Infers distributed RAM.
- Pointer, count and flag logic stays in rx_fifo.

Test Plan:
- Reset then idle -> o_empty=1, o_count=0, o_rd_valid=0, o_overrun=0.
- Push 0x41, then 0x42, with i_rd_ready=0 -> cycle after first push: o_rd_valid=1, o_rd_data=0x41, o_count=1. Then o_count=2. Raise ready one cycle -> o_rd_data=0x42, o_count=1.
- Push 16 bytes 0x00..0x0F, no reads -> o_full=1, o_count=16. 17th push 0xAA -> dropped, o_overrun one-cycle pulse. Drain reads 0x00..0x0F in order, then o_empty=1.
- Full FIFO, push 0x55 with i_rd_ready=1 same cycle -> count stays 16, no overrun, 0x55 emerges as the 16th read.
- Stream 40 bytes with ready toggling 1/0, covering pointer wrap twice -> output order matches input, o_count tracks the model every cycle.
- Three bytes queued, assert i_reset mid-cycle -> o_rd_valid=0 and o_count=0 without waiting for a clock edge. With RX_FIFO_STICKY_OVERRUN_EN: after a drop, o_overrun stays 1 until the first pop.
